aes_key_sched_ctrl: RTL and testbench

// Sequencer for the AES-128 key-generation datapath: runs the two-stage key_gen pipe through rounds 1..NR and supplies rcon.

---
 rtl/aes_key_sched_ctrl.sv | 156 +++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
// Sequencer for the AES-128 key_gen pipe. It feeds the cipher key into a
// two-stage key_gen datapath (registered S-box in between) and steps it
// through rounds 1..NR. It also supplies the round constant and captures
// every round key into an (NR+1)-entry store that the cipher core reads.
//
// Ports
//   clk, nrst          clock, asynchronous active-low reset
//   start, abort       begin expansion of key_in / synchronous cancel
//   key_in             cipher key, sampled with an accepted start
//   busy, done         expansion in progress / one-cycle completion pulse
//   kg_en              key_gen enable (both stages)
//   kg_gen_key         rcon source select, tied to the controller rcon
//   kg_next_rnd        0: key_gen takes kg_key, 1: feedback of kg_key_o
//   kg_rcon            round constant, non-zero only in the second stage
//   kg_key             latched cipher key
//   kg_key_o           key_gen stage-2 output
//   rk_raddr, rk_rdata round-key read port, one cycle of latency
//   rk_valid           store holds a complete schedule
module aes_key_sched_ctrl #(
    parameter int unsigned NR    = 10,
    parameter int unsigned KEY_W = 128
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             abort,
    input  logic [KEY_W-1:0] key_in,
    output logic             busy,
    output logic             done,
    output logic             kg_en,
    output logic             kg_gen_key,
    output logic             kg_next_rnd,
    output logic [7:0]       kg_rcon,
    output logic [KEY_W-1:0] kg_key,
    input  logic [KEY_W-1:0] kg_key_o,
    input  logic [3:0]       rk_raddr,
    output logic [KEY_W-1:0] rk_rdata,
    output logic             rk_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RND_A = 2'd1;
    localparam logic [1:0] S_RND_B = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    localparam logic [3:0] LAST_RND = 4'(NR);

    logic [1:0]       state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic [7:0]       rcon_q, rcon_d;
    logic             done_q, done_d;
    logic             rk_valid_q, rk_valid_d;
    logic [KEY_W-1:0] kg_key_q, kg_key_d;
    logic             wr_pend_q, wr_pend_d;
    logic [3:0]       wr_idx_q, wr_idx_d;
    logic [KEY_W-1:0] rk_rdata_q, rk_rdata_d;
    logic [KEY_W-1:0] store_q [0:NR];
    logic [KEY_W-1:0] store_d [0:NR];

    always_comb begin
        state_d    = state_q;
        rnd_d      = rnd_q;
        rcon_d     = rcon_q;
        done_d     = 1'b0;
        rk_valid_d = rk_valid_q;
        kg_key_d   = kg_key_q;
        wr_pend_d  = 1'b0;
        wr_idx_d   = rnd_q;
        store_d    = store_q;

        // key_gen output lags RND_B by one cycle, so the store write for
        // round r lands on the edge after RND_B(r); abort cancels it.
        if (wr_pend_q && !abort) begin
            store_d[wr_idx_q] = kg_key_o;
        end

        rk_rdata_d = '0;
        if (rk_raddr <= LAST_RND) begin
            rk_rdata_d = store_q[rk_raddr];
        end

        if (abort) begin
            state_d    = S_IDLE;
            rnd_d      = '0;
            rk_valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        kg_key_d   = key_in;
                        store_d[0] = key_in;
                        rnd_d      = 4'd1;
                        rcon_d     = 8'h01;
                        rk_valid_d = 1'b0;
                        state_d    = S_RND_A;
                    end
                end
                S_RND_A: begin
                    state_d = S_RND_B;
                end
                S_RND_B: begin
                    rnd_d     = rnd_q + 4'd1;
                    // xtime: successive round constants in GF(2^8)
                    rcon_d    = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                    wr_pend_d = 1'b1;
                    state_d   = (rnd_q < LAST_RND) ? S_RND_A : S_FIN;
                end
                default: begin
                    rnd_d      = '0;
                    done_d     = 1'b1;
                    rk_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= S_IDLE;
            rnd_q      <= '0;
            rcon_q     <= '0;
            done_q     <= 1'b0;
            rk_valid_q <= 1'b0;
            kg_key_q   <= '0;
            wr_pend_q  <= 1'b0;
            wr_idx_q   <= '0;
            rk_rdata_q <= '0;
            store_q    <= '{default: '0};
        end else begin
            state_q    <= state_d;
            rnd_q      <= rnd_d;
            rcon_q     <= rcon_d;
            done_q     <= done_d;
            rk_valid_q <= rk_valid_d;
            kg_key_q   <= kg_key_d;
            wr_pend_q  <= wr_pend_d;
            wr_idx_q   <= wr_idx_d;
            rk_rdata_q <= rk_rdata_d;
            store_q    <= store_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign kg_en       = (state_q == S_RND_A) || (state_q == S_RND_B);
    assign kg_gen_key  = 1'b1;
    // Only the very first stage-1 pass takes the cipher key directly.
    assign kg_next_rnd = (state_q == S_RND_B) || ((state_q == S_RND_A) && (rnd_q != 4'd1));
    assign kg_rcon     = (state_q == S_RND_B) ? rcon_q : 8'h00;
    assign kg_key      = kg_key_q;
    assign rk_rdata    = rk_rdata_q;
    assign rk_valid    = rk_valid_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// tb_aes_key_sched_ctrl
// Bench for aes_key_sched_ctrl with a behavioural two-stage key_gen plus
// registered S-box attached to the kg_* ports. Expected round keys come
// from a software AES-128 key expansion and are queued at each start.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] KEY_FIPS = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
    localparam logic [127:0] RK1_FIPS = 128'ha0fafe17_88542cb1_23a33939_2a6c7605;
    localparam logic [127:0] RK10_FIPS = 128'hd014f9a8_c9ee2589_e13f0cc8_b6630ca6;
    localparam logic [127:0] RK10_ZERO = 128'hb4ef5bcb_3e92e211_23e951cf_6f8f188e;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy, done, kg_en, kg_gen_key, kg_next_rnd, rk_valid;
    logic [7:0]   kg_rcon;
    logic [127:0] kg_key, rk_rdata;
    logic [127:0] kg_key_o = '0;
    logic [3:0]   rk_raddr = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_q [$];
    logic [7:0]   rcon_tab [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    aes_key_sched_ctrl #(.NR(10), .KEY_W(128)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort), .key_in(key_in),
        .busy(busy), .done(done), .kg_en(kg_en), .kg_gen_key(kg_gen_key),
        .kg_next_rnd(kg_next_rnd), .kg_rcon(kg_rcon), .kg_key(kg_key),
        .kg_key_o(kg_key_o), .rk_raddr(rk_raddr), .rk_rdata(rk_rdata),
        .rk_valid(rk_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox8(input logic [7:0] a);
        logic [7:0] inv, sq, s;
        inv = 8'h01;
        sq  = a;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            inv = gmul(inv, sq);
        end
        s = inv ^ ((inv << 1) | (inv >> 7)) ^ ((inv << 2) | (inv >> 6))
                ^ ((inv << 3) | (inv >> 5)) ^ ((inv << 4) | (inv >> 4)) ^ 8'h63;
        return s;
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        logic [31:0] r;
        r = {w[23:0], w[31:24]};
        return {sbox8(r[31:24]), sbox8(r[23:16]), sbox8(r[15:8]), sbox8(r[7:0])};
    endfunction

    function automatic logic [127:0] kg_step(input logic [127:0] prev,
                                             input logic [31:0] subw,
                                             input logic [7:0] rc);
        logic [31:0] t, w4, w5, w6, w7;
        t  = subw ^ {rc, 24'h0};
        w4 = prev[127:96] ^ t;
        w5 = prev[95:64] ^ w4;
        w6 = prev[63:32] ^ w5;
        w7 = prev[31:0] ^ w6;
        return {w4, w5, w6, w7};
    endfunction

    // Behavioural key_gen: stage 1 plus registered S-box, then stage 2.
    logic [127:0] stage1_m = '0;
    logic [31:0]  sub_m = '0;
    always @(posedge clk) begin
        if (kg_en) begin
            stage1_m <= kg_next_rnd ? kg_key_o : kg_key;
            sub_m    <= sub_rot(kg_next_rnd ? kg_key_o[31:0] : kg_key[31:0]);
            kg_key_o <= kg_step(stage1_m, sub_m, kg_rcon);
        end
    end

    // Cycle-indexed monitor: cycle 1 is the first cycle after the start edge.
    int cyc_ctr = 0;
    int t0 = 0;
    bit mon_en = 1'b0;
    always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

    always @(negedge clk) begin
        int c;
        logic [7:0] e_rcon;
        if (mon_en) begin
            c = cyc_ctr - t0;
            e_rcon = (c >= 2 && c <= 20 && (c % 2) == 0) ? rcon_tab[c / 2] : 8'h00;
            vectors += 6;
            if (busy !== (c >= 1 && c <= 21)) begin
                miscompares++;
                $display("FAIL mon_busy cyc %0d: got %b want %b", c, busy, (c >= 1 && c <= 21));
            end
            if (kg_en !== (c >= 1 && c <= 20)) begin
                miscompares++;
                $display("FAIL mon_kg_en cyc %0d: got %b want %b", c, kg_en, (c >= 1 && c <= 20));
            end
            if (kg_next_rnd !== (c >= 2 && c <= 20)) begin
                miscompares++;
                $display("FAIL mon_next_rnd cyc %0d: got %b want %b", c, kg_next_rnd, (c >= 2 && c <= 20));
            end
            if (kg_rcon !== e_rcon) begin
                miscompares++;
                $display("FAIL mon_rcon cyc %0d: got %h want %h", c, kg_rcon, e_rcon);
            end
            if (done !== (c == 22)) begin
                miscompares++;
                $display("FAIL mon_done cyc %0d: got %b want %b", c, done, (c == 22));
            end
            if (kg_gen_key !== 1'b1) begin
                miscompares++;
                $display("FAIL mon_gen_key cyc %0d: got %b want 1", c, kg_gen_key);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_schedule(input logic [127:0] key);
        logic [127:0] rk;
        rk = key;
        exp_q.push_back(rk);
        for (int r = 1; r <= 10; r++) begin
            rk = kg_step(rk, sub_rot(rk[31:0]), rcon_tab[r]);
            exp_q.push_back(rk);
        end
    endtask

    task automatic read_rk(input logic [3:0] idx, output logic [127:0] data);
        rk_raddr = idx;
        tick();
        data = rk_rdata;
    endtask

    // Pulses start for one edge and leaves the bench in cycle 1.
    task automatic launch(input logic [127:0] key);
        key_in = key;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        t0     = cyc_ctr - 1;
        mon_en = 1'b1;
    endtask

    task automatic test_reset();
        rk_raddr = 4'd0;
        repeat (3) tick();
        vectors++;
        if ({busy, done, kg_en, kg_next_rnd, rk_valid} !== 5'b0 || kg_rcon !== 8'h00
                || kg_key !== '0 || rk_rdata !== '0 || kg_gen_key !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_outputs: got ctl=%b rcon=%h key=%h rd=%h gk=%b want all 0, gk=1",
                     {busy, done, kg_en, kg_next_rnd, rk_valid}, kg_rcon, kg_key, rk_rdata, kg_gen_key);
        end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_fips();
        logic [127:0] d, e;
        push_schedule(KEY_FIPS);
        launch(KEY_FIPS);
        for (int c = 1; c <= 21; c++) begin
            vectors++;
            if (rk_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fips_rk_valid_early cyc %0d: got %b want 0", c, rk_valid);
            end
            tick();
        end
        vectors++;
        if (rk_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL fips_rk_valid cyc 22: got %b want 1", rk_valid);
        end
        tick();
        mon_en = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_rk(4'(i), d);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (d !== e) begin
                miscompares++;
                $display("FAIL fips_rk[%0d]: got %h want %h", i, d, e);
            end
            if (i == 1) begin
                vectors++;
                if (d !== RK1_FIPS) begin
                    miscompares++;
                    $display("FAIL fips_rk1_const: got %h want %h", d, RK1_FIPS);
                end
            end
            if (i == 10) begin
                vectors++;
                if (d !== RK10_FIPS) begin
                    miscompares++;
                    $display("FAIL fips_rk10_const: got %h want %h", d, RK10_FIPS);
                end
            end
        end
        read_rk(4'd15, d);
        vectors++;
        if (d !== '0) begin
            miscompares++;
            $display("FAIL fips_oob_read: got %h want 0", d);
        end
    endtask

    task automatic test_start_while_busy();
        logic [127:0] d, e;
        push_schedule(KEY_FIPS);
        launch(KEY_FIPS);
        repeat (6) tick();
        key_in = '1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (14) tick();
        vectors++;
        if (rk_valid !== 1'b1 || done !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_start_done cyc 22: got done=%b valid=%b want 1 1", done, rk_valid);
        end
        tick();
        mon_en = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_rk(4'(i), d);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (d !== e) begin
                miscompares++;
                $display("FAIL busy_start_rk[%0d]: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_abort();
        logic [127:0] d, e;
        launch(KEY_FIPS);
        repeat (8) tick();
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort  = 1'b0;
        start  = 1'b0;
        mon_en = 1'b0;
        vectors++;
        if ({busy, kg_en, rk_valid, done} !== 4'b0000 || kg_rcon !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_idle: got busy,en,valid,done=%b rcon=%h want 0000 00",
                     {busy, kg_en, rk_valid, done}, kg_rcon);
        end
        for (int c = 0; c < 15; c++) begin
            tick();
            vectors++;
            if ({done, busy, rk_valid} !== 3'b000) begin
                miscompares++;
                $display("FAIL abort_quiet +%0d: got done,busy,valid=%b want 000", c, {done, busy, rk_valid});
            end
        end
        push_schedule('0);
        launch('0);
        repeat (22) tick();
        mon_en = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_rk(4'(i), d);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (d !== e) begin
                miscompares++;
                $display("FAIL zero_key_rk[%0d]: got %h want %h", i, d, e);
            end
            if (i == 10) begin
                vectors++;
                if (d !== RK10_ZERO) begin
                    miscompares++;
                    $display("FAIL zero_key_rk10_const: got %h want %h", d, RK10_ZERO);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] d, e, key_b;
        key_b = {$urandom(), $urandom(), $urandom(), $urandom()};
        key_in = KEY_FIPS;
        start  = 1'b1;
        tick();
        t0     = cyc_ctr - 1;
        mon_en = 1'b1;
        repeat (9) tick();
        key_in = key_b;
        repeat (12) tick();
        vectors++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_first_done: got done=%b busy=%b want 1 0", done, busy);
        end
        push_schedule(key_b);
        tick();
        start = 1'b0;
        t0    = cyc_ctr - 1;
        vectors++;
        if (busy !== 1'b1 || rk_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_second_start: got busy=%b valid=%b want 1 0", busy, rk_valid);
        end
        repeat (22) tick();
        mon_en = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            read_rk(4'(i), d);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (d !== e) begin
                miscompares++;
                $display("FAIL b2b_rk[%0d]: got %h want %h", i, d, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] d, e;
        launch(KEY_FIPS);
        repeat (11) tick();
        mon_en = 1'b0;
        nrst   = 1'b0;
        #2;
        vectors++;
        if ({busy, done, kg_en, kg_next_rnd, rk_valid} !== 5'b0 || kg_rcon !== 8'h00
                || kg_key !== '0 || rk_rdata !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_outputs: got ctl=%b rcon=%h key=%h rd=%h want all 0",
                     {busy, done, kg_en, kg_next_rnd, rk_valid}, kg_rcon, kg_key, rk_rdata);
        end
        repeat (2) tick();
        nrst = 1'b1;
        for (int i = 0; i <= 10; i++) exp_q.push_back('0);
        for (int i = 0; i <= 10; i++) begin
            read_rk(4'(i), d);
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 'x;
            vectors++;
            if (d !== e) begin
                miscompares++;
                $display("FAIL reset_mid_rk[%0d]: got %h want %h", i, d, e);
            end
        end
        read_rk(4'd15, d);
        vectors++;
        if (d !== '0) begin
            miscompares++;
            $display("FAIL reset_mid_oob: got %h want 0", d);
        end
    endtask

    initial begin
        test_reset();
        test_fips();
        test_start_while_busy();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1);
    end

endmodule
